// File: rtl/fetch_pkg.sv
// Shared encodings and state type for the instruction-fetch stage.
// No logic beyond the PC write-enable decode helper.
// No flow control of its own.
package fetch_pkg;

    localparam logic [1:0] PCWE_HOLD   = 2'd0;
    localparam logic [1:0] PCWE_ALWAYS = 2'd1;
    localparam logic [1:0] PCWE_ZERO   = 2'd2;

    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FLUSH,
        S_VALID
    } fetch_state_t;

    // Encoding 3 is reserved and behaves exactly like hold.
    function automatic logic pc_write_en(input logic [1:0] pc_we, input logic alu_zero);
        case (pc_we)
            PCWE_HOLD:   return 1'b0;
            PCWE_ALWAYS: return 1'b1;
            PCWE_ZERO:   return alu_zero;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ready/data back.
// Memory answers combinationally in the cycle it raises imem_ready.
// Requester holds imem_req/imem_addr stable until imem_ready.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection, JR alignment force and JR misalignment detect.
// Purely combinational, zero latency.
// No flow control.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_target,
    input  logic [31:0] rs_data,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc,
    output logic        jr_misalign
);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_INC: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = branch_target;
            PCSRC_JR:  next_pc = {rs_data[31:2], 2'b00};
            PCSRC_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        endcase
    end

    assign jr_misalign = (pc_src == PCSRC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// PC/IR owner with one-word prefetch buffer; FETCH_STATS_EN adds fetch/redirect counters.
// imem_ready at cycle N gives fetch_valid at N+1; commit-to-next-valid is 2 cycles at zero wait.
// Waits on imem_ready indefinitely; controller must hold ir_we until fetch_valid.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pc_we,
    input  logic [1:0]         pc_src,
    input  logic               ir_we,
    input  logic               alu_zero,
    input  logic [31:0]        branch_target,
    input  logic [31:0]        rs_data,
    fetch_unit_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instruction,
    output logic               fetch_valid,
    output logic               misalign
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  buf_q;
    logic [31:0]  addr_q;
    logic [31:0]  next_pc;
    logic         jr_misalign;
    logic         commit;
    logic         pc_write;
    logic         capture;

    assign fetch_valid = (state_q == S_VALID);
    assign commit      = ir_we && fetch_valid;
    // An ir_we that cannot commit also suppresses the PC write it came with.
    assign pc_write    = pc_write_en(pc_we, alu_zero) && (commit || !ir_we);
    assign pc_plus4    = pc + 32'd4;

    fetch_next_pc u_next_pc (
        .pc_src        (pc_src),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .rs_data       (rs_data),
        .jump_index    (instruction[25:0]),
        .next_pc       (next_pc),
        .jr_misalign   (jr_misalign)
    );

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = {pc[31:2], 2'b00};
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    capture = !pc_write;
                    state_d = pc_write ? S_REQ : S_VALID;
                end else if (pc_write) begin
                    state_d = S_FLUSH;
                end
            end
            // Old request must still complete on the bus before re-requesting.
            S_FLUSH: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = addr_q;
                if (imem.imem_ready) begin
                    state_d = S_REQ;
                end
            end
            S_VALID: begin
                if (commit || pc_write) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            buf_q       <= 32'h0;
            addr_q      <= 32'h0;
            misalign    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pc_write) begin
                pc <= next_pc;
            end
            if (commit) begin
                instruction <= buf_q;
            end
            if (capture) begin
                buf_q <= imem.imem_rdata;
            end
            if (state_q == S_REQ) begin
                addr_q <= {pc[31:2], 2'b00};
            end
            if (pc_write && jr_misalign) begin
                misalign <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count    <= 32'h0;
            redirect_count <= 32'h0;
        end else begin
            if (commit) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (pc_write && !(commit && pc_src == PCSRC_INC)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Owns the PC register and the instruction register (IR), and drives an instruction-memory request/ready handshake.
- Prefetches the word at PC and presents it to the controller; applies the controller's pc_we/pc_src/ir_we strobes.
- Discards stale prefetches when the PC is redirected by a branch, JR or JAL.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_we  in  2  0 = hold; 1 = unconditional write; 2 = write if alu_zero; 3 = reserved, treated as hold.
- pc_src  in  2  0 = pc_plus4; 1 = branch_target; 2 = rs_data (JR); 3 = jump target.
- ir_we  in  1  controller IF strobe: capture the fetched instruction.
- alu_zero  in  1  ALU zero flag, used when pc_we == 2.
- branch_target  in  32  latched ALU branch address.
- rs_data  in  32  register-file rs value, used for JR.
- imem_req  out  1  memory read request.
- imem_addr  out  32  read address; word-aligned.
- imem_ready  in  1  memory has data on imem_rdata this cycle.
- imem_rdata  in  32  read data.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32.
- instruction  out  32  IR contents.
- fetch_valid  out  1  prefetch buffer holds the word for the current pc.
- misalign  out  1  sticky: a JR target had nonzero bits [1:0].

Behaviour:
- Reset (async, rst_n low), applied immediately including mid-transaction; any outstanding memory response is ignored:
  - pc = RESET_PC; instruction = 0; buffer = 0.
  - imem_req = 0; fetch_valid = 0; misalign = 0.
  - state = S_IDLE.
- Jump target = {pc_plus4[31:28], instruction[25:0], 2'b00}.
- Commit = ir_we && fetch_valid. ir_we while !fetch_valid is ignored entirely: no IR update and no PC write. The controller must hold in IF until fetch_valid.
- PC write enable: (pc_we == 1) || (pc_we == 2 && alu_zero). It is gated by commit when ir_we is also high. The new PC is the value selected by pc_src.
- On JR, PC bits [1:0] are forced to 0. If rs_data[1:0] != 0, misalign is set; it clears only on reset.
- Fetch FSM:
  - S_IDLE: imem_req = 0. Next cycle -> S_REQ.
  - S_REQ: imem_req = 1, imem_addr = pc, held stable until imem_ready.
    - imem_ready, no PC write this cycle: buffer <= imem_rdata -> S_VALID.
    - imem_ready with a PC write in the same cycle: data discarded -> S_REQ at the new pc.
    - PC write without imem_ready: -> S_FLUSH.
  - S_FLUSH: imem_req = 1, imem_addr = the old address, captured in an addr register. On imem_ready the data is discarded -> S_REQ. Further PC writes stay in S_FLUSH.
  - S_VALID: fetch_valid = 1, imem_req = 0.
    - Commit: instruction <= buffer and the PC write applies, normally pc+4 -> S_REQ (prefetch next).
    - PC write without commit (redirect): -> S_REQ; fetch_valid drops the next cycle.
- Latency: imem_ready at cycle N gives fetch_valid = 1 at N+1. With zero-wait memory, commit-to-next-valid is 2 cycles.
- Reserved encoding pc_we == 3 never writes the PC and never invalidates the buffer.
- imem_ready outside S_REQ/S_FLUSH is ignored.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs fetch_count[31:0] and redirect_count[31:0].
  - fetch_count increments on every commit.
  - redirect_count increments on every PC write that is not a commit-with-pc_src-0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - pc_we encodings: PCWE_HOLD = 0, PCWE_ALWAYS = 1, PCWE_ZERO = 2.
  - pc_src encodings: PCSRC_INC = 0, PCSRC_BR = 1, PCSRC_JR = 2, PCSRC_J = 3.
  - Fetch state enum: S_IDLE, S_REQ, S_FLUSH, S_VALID.
- One sub-module: fetch_next_pc, the combinational next-PC mux, alignment force and misalign detect.

Test Plan:
- Reset, memory ready=1 returning 32'h2008_0005 at address 0 -> imem_req at cycle 1, fetch_valid at cycle 2; ir_we commit -> instruction = 32'h2008_0005, pc = 4.
- Memory with 3 wait states -> imem_addr held stable and imem_req high for 4 cycles. ir_we pulses during the wait are ignored: pc stays 0, instruction unchanged.
- S_VALID at pc = 8, pc_we = 2, pc_src = 1, branch_target = 32'h40:
  - alu_zero = 1 -> pc = 32'h40 and re-request at 32'h40.
  - alu_zero = 0 -> pc stays 8 and fetch_valid stays 1.
- Redirect during an outstanding request (pc_we = 1, pc_src = 2, rs_data = 32'h103) -> pc = 32'h100, misalign = 1. The old request completes with data discarded, then a new request at 32'h100.
- JAL: instruction = 32'h0C00_0010, pc = 32'h0040_0004, pc_we = 1, pc_src = 3 -> pc = 32'h0000_0040.
- rst_n low during S_FLUSH -> imem_req drops combinationally, pc = RESET_PC. After release, normal fetch from RESET_PC; the late imem_ready is ignored.
